// File: rtl/mem_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and data access,
// DM first, with fetch cancellation and a watchdog that converts a hung access into a zero response.
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        if_cancel,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        Done_IM,
  output logic [15:0] if_rdata,
  output logic        Done_DM,
  output logic [15:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_valid,
  output logic        err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY_IF = 3'd1,
    BUSY_DM = 3'd2,
    RESP_IF = 3'd3,
    RESP_DM = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic          kill, kill_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          err_nx;
  logic          mem_en_nx, mem_wr_nx;
  logic [15:0]   mem_addr_nx, mem_wdata_nx;
  logic [15:0]   if_rdata_nx, dm_rdata_nx;
  logic          respond, expire, drop;

  // A response in the issue cycle is illegal and must not complete the access.
  assign respond = mem_valid & ~mem_en;
  assign expire  = (cnt == CW'(TIMEOUT - 1));
  assign drop    = kill | if_cancel;

  assign Done_DM = ~dm_req | (state == RESP_DM);
  assign Done_IM = ~if_req | ((state == RESP_IF) & ~if_cancel);

  // Next-state, issue and capture logic.
  always_comb begin
    state_nx     = state;
    kill_nx      = kill;
    cnt_nx       = cnt;
    err_nx       = err;
    mem_en_nx    = 1'b0;
    mem_wr_nx    = mem_wr;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    if_rdata_nx  = if_rdata;
    dm_rdata_nx  = dm_rdata;
    case (state)
      IDLE: begin
        kill_nx = 1'b0;
        cnt_nx  = '0;
        if (dm_req) begin
          state_nx     = BUSY_DM;
          mem_en_nx    = 1'b1;
          mem_wr_nx    = dm_wr;
          mem_addr_nx  = dm_addr;
          mem_wdata_nx = dm_wdata;
        end else if (if_req && !if_cancel) begin
          state_nx     = BUSY_IF;
          mem_en_nx    = 1'b1;
          mem_wr_nx    = 1'b0;
          mem_addr_nx  = if_addr;
          mem_wdata_nx = 16'h0000;
        end else begin
          state_nx = IDLE;
        end
      end
      BUSY_IF: begin
        if (respond || expire) begin
          kill_nx = 1'b0;
          if (!respond) begin
            err_nx = 1'b1;
          end else begin
            err_nx = err;
          end
          if (drop) begin
            state_nx = IDLE;
          end else begin
            state_nx    = RESP_IF;
            if_rdata_nx = respond ? mem_rdata : 16'h0000;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
          if (if_cancel) begin
            kill_nx = 1'b1;
          end else begin
            kill_nx = kill;
          end
        end
      end
      BUSY_DM: begin
        if (respond || expire) begin
          state_nx = RESP_DM;
          if (!respond) begin
            err_nx = 1'b1;
          end else begin
            err_nx = err;
          end
          // Stores leave the last load result untouched.
          if (!mem_wr) begin
            dm_rdata_nx = respond ? mem_rdata : 16'h0000;
          end else begin
            dm_rdata_nx = dm_rdata;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      RESP_IF: state_nx = IDLE;
      RESP_DM: state_nx = IDLE;
      default: begin
        state_nx = IDLE;
        kill_nx  = 1'b0;
        cnt_nx   = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      kill      <= 1'b0;
      cnt       <= '0;
      err       <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
      if_rdata  <= 16'h0000;
      dm_rdata  <= 16'h0000;
    end else begin
      state     <= state_nx;
      kill      <= kill_nx;
      cnt       <= cnt_nx;
      err       <= err_nx;
      mem_en    <= mem_en_nx;
      mem_wr    <= mem_wr_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      if_rdata  <= if_rdata_nx;
      dm_rdata  <= dm_rdata_nx;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected issues and completions,
// a memory model and a completion monitor pop and compare them independently.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_cancel, dm_req, dm_wr;
  logic [15:0] if_addr, dm_addr, dm_wdata;
  logic        Done_IM, Done_DM, mem_en, mem_wr, mem_valid, err;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        chk_wd;
    int          lat;
    logic [15:0] data;
    logic        hang;
  } iss_t;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } done_t;

  iss_t  iss_q[$];
  done_t dm_q[$];
  done_t if_q[$];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  mem_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .Done_IM(Done_IM), .if_rdata(if_rdata), .Done_DM(Done_DM), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_iss(input int c, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                          input logic cw, input int lat, input logic [15:0] d, input logic hang);
    iss_t e;
    e.cyc = c; e.wr = wr; e.addr = a; e.wdata = wd; e.chk_wd = cw;
    e.lat = lat; e.data = d; e.hang = hang;
    iss_q.push_back(e);
  endtask

  task automatic push_done(input logic is_dm, input int c, input logic [15:0] d);
    done_t e;
    e.cyc = c; e.data = d;
    if (is_dm) dm_q.push_back(e);
    else if_q.push_back(e);
  endtask

  task automatic run_dm(input logic wr, input logic [15:0] a, input logic [15:0] wd);
    logic ok;
    ok = 1'b0;
    dm_wr = wr; dm_addr = a; dm_wdata = wd; dm_req = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (Done_DM) begin
        ok = 1'b1;
        break;
      end
    end
    chk("dm_done_seen", 32'(ok), 32'd1);
    tick();
    dm_req = 1'b0;
  endtask

  task automatic run_if(input logic [15:0] a);
    logic ok;
    ok = 1'b0;
    if_addr = a; if_req = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (Done_IM) begin
        ok = 1'b1;
        break;
      end
    end
    chk("if_done_seen", 32'(ok), 32'd1);
    tick();
    if_req = 1'b0;
  endtask

  // Memory model: checks every issue against the expected queue and answers after its latency.
  initial begin
    iss_t e;
    mem_valid = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst_n && mem_en) begin
        chk("issue_expected", 32'(iss_q.size() > 0), 32'd1);
        if (iss_q.size() > 0) begin
          e = iss_q.pop_front();
          chk("issue_cycle", 32'(cyc), 32'(e.cyc));
          chk("issue_wr", 32'(mem_wr), 32'(e.wr));
          chk("issue_addr", 32'(mem_addr), 32'(e.addr));
          if (e.chk_wd) chk("issue_wdata", 32'(mem_wdata), 32'(e.wdata));
          if (!e.hang) begin
            repeat (e.lat) @(posedge clk);
            #1;
            mem_valid = 1'b1;
            mem_rdata = e.data;
            @(posedge clk);
            #1;
            mem_valid = 1'b0;
            mem_rdata = 16'h0000;
          end
        end
      end
    end
  end

  // Completion monitor: a Done seen while the port requests must match the scoreboard head.
  initial begin
    done_t e;
    forever begin
      @(negedge clk);
      if (rst_n && dm_req && Done_DM) begin
        chk("dm_done_expected", 32'(dm_q.size() > 0), 32'd1);
        if (dm_q.size() > 0) begin
          e = dm_q.pop_front();
          chk("dm_done_cycle", 32'(cyc), 32'(e.cyc));
          chk("dm_rdata", 32'(dm_rdata), 32'(e.data));
        end
      end
      if (rst_n && if_req && Done_IM) begin
        chk("if_done_expected", 32'(if_q.size() > 0), 32'd1);
        if (if_q.size() > 0) begin
          e = if_q.pop_front();
          chk("if_done_cycle", 32'(cyc), 32'(e.cyc));
          chk("if_rdata", 32'(if_rdata), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    if_req = 1'b0; if_cancel = 1'b0; if_addr = 16'h0000;
    dm_req = 1'b0; dm_wr = 1'b0; dm_addr = 16'h0000; dm_wdata = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done_im", 32'(Done_IM), 32'd1);
    chk("rst_done_dm", 32'(Done_DM), 32'd1);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dm_rdata", 32'(dm_rdata), 32'd0);
    rst_n = 1'b1;

    // Isolated load, L = 3.
    tick();
    n = cyc;
    push_iss(n + 1, 1'b0, 16'h0040, 16'h0000, 1'b1, 3, 16'hBEEF, 1'b0);
    push_done(1'b1, n + 5, 16'hBEEF);
    run_dm(1'b0, 16'h0040, 16'h0000);

    // Simultaneous store and fetch, L = 1: store keeps the old load data.
    tick();
    n = cyc;
    push_iss(n + 1, 1'b1, 16'h0080, 16'hA5A5, 1'b1, 1, 16'hDEAD, 1'b0);
    push_iss(n + 5, 1'b0, 16'h0100, 16'h0000, 1'b0, 1, 16'h1111, 1'b0);
    push_done(1'b1, n + 3, 16'hBEEF);
    push_done(1'b0, n + 7, 16'h1111);
    fork
      run_dm(1'b1, 16'h0080, 16'hA5A5);
      run_if(16'h0100);
    join

    // Fetch cancelled in BUSY_IF, L = 4: no Done, data untouched.
    tick();
    n = cyc;
    push_iss(n + 1, 1'b0, 16'h0200, 16'h0000, 1'b0, 4, 16'h2222, 1'b0);
    if_addr = 16'h0200;
    if_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if_cancel = (k == 2);
      @(negedge clk);
      chk("cancel_no_done", 32'(Done_IM), 32'd0);
      tick();
    end
    if_req = 1'b0;
    @(negedge clk);
    chk("cancel_if_rdata", 32'(if_rdata), 32'h1111);
    chk("cancel_no_reissue", 32'(mem_en), 32'd0);

    // Watchdog on a hung load.
    tick();
    n = cyc;
    push_iss(n + 1, 1'b0, 16'h0300, 16'h0000, 1'b1, 0, 16'h0000, 1'b1);
    push_done(1'b1, n + 17, 16'h0000);
    fork
      run_dm(1'b0, 16'h0300, 16'h0000);
      begin
        repeat (16) @(posedge clk);
        @(negedge clk);
        chk("wd_err_before", 32'(err), 32'd0);
        @(negedge clk);
        chk("wd_err_set", 32'(err), 32'd1);
      end
    join

    // Later fetch, L = 2: err stays set.
    tick();
    n = cyc;
    push_iss(n + 1, 1'b0, 16'h0400, 16'h0000, 1'b0, 2, 16'h1234, 1'b0);
    push_done(1'b0, n + 4, 16'h1234);
    run_if(16'h0400);
    chk("wd_err_sticky", 32'(err), 32'd1);

    // Reset in the middle of a store, L = 6; its late response must be ignored.
    tick();
    n = cyc;
    push_iss(n + 1, 1'b1, 16'h0500, 16'h5A5A, 1'b1, 6, 16'h7777, 1'b0);
    dm_wr = 1'b1; dm_addr = 16'h0500; dm_wdata = 16'h5A5A; dm_req = 1'b1;
    tick();
    tick();
    chk("pre_rst_mem_addr", 32'(mem_addr), 32'h0500);
    #3;
    dm_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
    chk("mid_rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("mid_rst_if_rdata", 32'(if_rdata), 32'd0);
    chk("mid_rst_dm_rdata", 32'(dm_rdata), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_done_im", 32'(Done_IM), 32'd1);
    chk("mid_rst_done_dm", 32'(Done_DM), 32'd1);
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("late_valid_dm_rdata", 32'(dm_rdata), 32'd0);
    chk("late_valid_mem_en", 32'(mem_en), 32'd0);

    // Normal load after reset, L = 1.
    tick();
    n = cyc;
    push_iss(n + 1, 1'b0, 16'h0600, 16'h0000, 1'b1, 1, 16'hCAFE, 1'b0);
    push_done(1'b1, n + 3, 16'hCAFE);
    run_dm(1'b0, 16'h0600, 16'h0000);
    repeat (3) tick();

    chk("issue_queue_drained", 32'(iss_q.size()), 32'd0);
    chk("dm_queue_drained", 32'(dm_q.size()), 32'd0);
    chk("if_queue_drained", 32'(if_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
